signed_display_scanner: RTL

Registered, time-multiplexed driver for a bank of 7-segment digits showing a signed or unsigned WIDTH-bit result. A load strobe captures the value. An iterative shift-add-3 (double-dabble) converter produces BCD over WIDTH cycles. The block then drives DIGITS multiplexed digits, with the leftmost digit reserved for the sign. It sits between the ALU/result register and the board's anode/segment pins, and adds the scan timer, sequential conversion, leading-zero blanking and overflow indication.

---
 rtl/signed_display_scanner_pkg.sv | 31 +++
 rtl/signed_display_scanner_bin2bcd_seq.sv | 55 +++++
 rtl/signed_display_scanner.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/signed_display_scanner_pkg.sv
// Shared digit codes, segment patterns and FSM encoding for the signed display scanner.
package signed_display_scanner_pkg;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Active-high {g,f,e,d,c,b,a}; polarity is applied only at the pins.
    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        case (code)
            4'd0:    seg_pattern = 7'h3F;
            4'd1:    seg_pattern = 7'h06;
            4'd2:    seg_pattern = 7'h5B;
            4'd3:    seg_pattern = 7'h4F;
            4'd4:    seg_pattern = 7'h66;
            4'd5:    seg_pattern = 7'h6D;
            4'd6:    seg_pattern = 7'h7D;
            4'd7:    seg_pattern = 7'h07;
            4'd8:    seg_pattern = 7'h7F;
            4'd9:    seg_pattern = 7'h6F;
            4'd10:   seg_pattern = 7'h40;
            default: seg_pattern = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/signed_display_scanner_bin2bcd_seq.sv
// Iterative shift-add-3 (double-dabble) binary to BCD converter, one bit per clock.
module bin2bcd_seq #(
    parameter  int WIDTH = 9,
    localparam int NB    = (WIDTH + 2) / 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  bin,
    output logic              busy,
    output logic              done,
    output logic [4*NB-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_reg;
    logic [4*NB-1:0]  bcd_reg;
    logic [4*NB-1:0]  bcd_adj;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;

    for (genvar gi = 0; gi < NB; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else if (start && !busy_reg) begin
            shift_reg <= bin;
            bcd_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            bcd_reg   <= {bcd_adj[4*NB-2:0], shift_reg[WIDTH-1]};
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            count_reg <= count_reg + CW'(1);
            if (count_reg == CW'(WIDTH - 1)) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // High in the cycle whose closing edge applies the final shift, so the
    // caller sees a complete bcd on the following cycle.
    assign done = busy_reg && (count_reg == CW'(WIDTH - 1));
    assign busy = busy_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/signed_display_scanner.sv
// Captures a signed/unsigned result, converts it to BCD and scans it onto a
// multiplexed 7-segment bank with a fixed leftmost sign digit.
module signed_display_scanner
    import signed_display_scanner_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int COMMON_ANODE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  value,
    input  logic              is_signed,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        sseg
);

    localparam int NB   = (WIDTH + 2) / 3;
    localparam int ND   = DIGITS - 1;
    localparam int PADD = (NB > ND) ? NB : ND;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t            state_reg, state_next;
    logic              neg_reg;
    logic              accept;
    logic              neg_in;
    logic [WIDTH-1:0]  mag_in;
    logic              eng_busy, eng_done;
    logic [4*NB-1:0]   eng_bcd;
    logic [4*PADD-1:0] bcd_pad;
    logic [3:0]        code_reg  [DIGITS];
    logic [3:0]        code_next [DIGITS];
    logic              ovf_reg, ovf_next, nz;
    logic [CNTW-1:0]   refresh_reg;
    logic [IDXW-1:0]   scan_idx_reg;
    logic [DIGITS-1:0] an_onehot;
    logic [DIGITS-1:0] an_reg;
    logic [6:0]        sseg_reg;
    logic [3:0]        sel_code;

    // The done cycle also accepts a load, so only an active conversion blocks capture.
    assign accept = load && (state_reg != CONV);
    assign neg_in = is_signed & value[WIDTH-1];
    assign mag_in = neg_in ? (~value + WIDTH'(1)) : value;

    bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .bin   (mag_in),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            neg_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                neg_reg <= neg_in;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CONV;
            CONV:    if (eng_done) state_next = UPDATE;
            UPDATE:  state_next = accept ? CONV : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Walk from the top numeric digit down so nz marks "something nonzero at or above here".
    always_comb begin
        bcd_pad = '0;
        bcd_pad[4*NB-1:0] = eng_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            code_next[i] = CODE_BLANK;
        end
        ovf_next = 1'b0;
        for (int i = ND; i < PADD; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) ovf_next = 1'b1;
        end
        nz = 1'b0;
        for (int i = ND - 1; i >= 0; i--) begin
            nz = nz | (bcd_pad[4*i +: 4] != 4'd0);
            if (ovf_next)            code_next[i] = CODE_DASH;
            else if (nz || (i == 0)) code_next[i] = bcd_pad[4*i +: 4];
            else                     code_next[i] = CODE_BLANK;
        end
        code_next[ND] = (neg_reg && !ovf_next) ? CODE_DASH : CODE_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                code_reg[i] <= CODE_BLANK;
            end
            ovf_reg <= 1'b0;
        end else if (state_reg == UPDATE) begin
            code_reg <= code_next;
            ovf_reg  <= ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_reg  <= '0;
            scan_idx_reg <= '0;
        end else if (refresh_reg == CNTW'(REFRESH_DIV - 1)) begin
            refresh_reg  <= '0;
            scan_idx_reg <= (scan_idx_reg == IDXW'(DIGITS - 1)) ? '0 : scan_idx_reg + IDXW'(1);
        end else begin
            refresh_reg <= refresh_reg + CNTW'(1);
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
        assign an_onehot[gi] = (scan_idx_reg == IDXW'(gi));
    end

    always_comb begin
        sel_code = CODE_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_reg == IDXW'(i)) sel_code = code_reg[i];
        end
    end

    // Anode and segments share one register stage so they always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg   <= '0;
            sseg_reg <= '0;
        end else begin
            an_reg   <= an_onehot;
            sseg_reg <= seg_pattern(sel_code);
        end
    end

    assign an   = (COMMON_ANODE != 0) ? ~an_reg   : an_reg;
    assign sseg = (COMMON_ANODE != 0) ? ~sseg_reg : sseg_reg;
    assign busy = eng_busy;
    assign done = (state_reg == UPDATE);
    assign ovf  = ovf_reg;

endmodule
